// File: rtl/light_sequencer_pkg.sv
// Shared state codes and widths for the light-show delay states and the
// sequencer that paces the LED patterns.
package light_sequencer_pkg;

   localparam logic [1:0] ST_DELAY2   = 2'b00;
   localparam logic [1:0] ST_DELAY_P1 = 2'b01;
   localparam logic [1:0] ST_DELAY1   = 2'b10;

   localparam int DIV_W   = 27;
   localparam int COUNT_W = 6;
   localparam int REP_W   = 4;
   localparam int LED_W   = 10;

   typedef logic [DIV_W-1:0] period_t;

   // Code 11 is unused by the state machine and shares the delay1 period.
   function automatic period_t select_period(input logic [1:0] code,
                                             input period_t d2,
                                             input period_t dp1,
                                             input period_t d1);
      case (code)
         ST_DELAY2:   return d2;
         ST_DELAY_P1: return dp1;
         default:     return d1;
      endcase
   endfunction

endpackage

// File: rtl/light_sequencer_tick_gen.sv
// Clock divider producing a one-cycle tick every 'period' enabled cycles.
module tick_gen
   import light_sequencer_pkg::*;
(
   input  logic    clk,
   input  logic    reset,
   input  logic    clear,
   input  logic    run,
   input  period_t period,
   output logic    tick
);

   period_t div_reg;
   logic    at_end;

   assign at_end = (div_reg == (period - DIV_W'(1)));
   // A clear cycle restarts the period, so its tick is swallowed.
   assign tick   = run && !clear && at_end;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_reg <= '0;
      end else if (clear) begin
         div_reg <= '0;
      end else if (run) begin
         div_reg <= at_end ? '0 : div_reg + DIV_W'(1);
      end
   end

endmodule

// File: rtl/light_sequencer.sv
// Steps an LED pattern at a rate chosen by the light-show delay state and
// counts down delayPoint1 repetitions.
module light_sequencer
   import light_sequencer_pkg::*;
#(
   parameter int DIV_D2  = 100_000_000,
   parameter int DIV_DP1 = 5_000_000,
   parameter int DIV_D1  = 50_000_000,
   parameter int STEPS   = 10,
   parameter int REPS    = 3
)
(
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         state,
   input  logic               enable,
   output logic [COUNT_W-1:0] count,
   output logic [REP_W-1:0]   repCount,
   output logic [LED_W-1:0]   ledPattern,
   output logic               tick
);

   localparam logic [COUNT_W-1:0] LAST_STEP = COUNT_W'(STEPS - 1);
   localparam logic [REP_W-1:0]   REP_LOAD  = REP_W'(REPS);

   logic [1:0]         prev_state_reg;
   logic               state_change;
   period_t            period;
   logic [COUNT_W-1:0] count_reg;
   logic [REP_W-1:0]   rep_reg;
   logic [LED_W-1:0]   led_reg;
   logic [LED_W-1:0]   one_hot;
   logic [LED_W-1:0]   bar;
   logic [LED_W-1:0]   pattern_next;

   assign state_change = (state != prev_state_reg);
   assign period = select_period(state, period_t'(DIV_D2), period_t'(DIV_DP1),
                                 period_t'(DIV_D1));

   tick_gen u_tick_gen (
      .clk    (clk),
      .reset  (reset),
      .clear  (state_change),
      .run    (enable),
      .period (period),
      .tick   (tick)
   );

   // A state change outranks a coincident tick: restart the show cleanly.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_state_reg <= ST_DELAY2;
         count_reg      <= '0;
         rep_reg        <= REP_LOAD;
      end else begin
         prev_state_reg <= state;
         if (state_change) begin
            count_reg <= '0;
            rep_reg   <= REP_LOAD;
         end else if (tick) begin
            count_reg <= (count_reg == LAST_STEP) ? '0 : count_reg + COUNT_W'(1);
            if (state == ST_DELAY_P1 && count_reg == LAST_STEP && rep_reg != '0) begin
               rep_reg <= rep_reg - REP_W'(1);
            end
         end
      end
   end

   // Per-LED decode; counts past the last LED naturally clear one-hot and fill the bar.
   generate
      for (genvar gi = 0; gi < LED_W; gi++) begin : g_led
         assign one_hot[gi] = (count_reg == COUNT_W'(gi));
         assign bar[gi]     = (count_reg >= COUNT_W'(gi));
      end
   endgenerate

   always_comb begin
      pattern_next = '0;
      case (state)
         ST_DELAY2:   pattern_next = one_hot;
         ST_DELAY_P1: pattern_next = bar;
         default:     pattern_next = {LED_W{~count_reg[0]}};
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         led_reg <= '0;
      end else begin
         led_reg <= enable ? pattern_next : '0;
      end
   end

   assign count      = count_reg;
   assign repCount   = rep_reg;
   assign ledPattern = led_reg;

endmodule

// File: tb/tb_light_sequencer.sv
// Directed scenarios plus randomized traffic checked cycle by cycle against
// an arithmetic model of the sequencer behaviour.
module tb_light_sequencer;

   localparam int D2 = 8, DP1 = 2, D1 = 4, STEPS = 10, REPS = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] state = 2'b00;
   logic       enable = 1'b0;
   logic [5:0] count;
   logic [3:0] repCount;
   logic [9:0] ledPattern;
   logic       tick;

   int checks = 0;
   int errors = 0;

   // Model: cycles elapsed in the current period, step, repetitions left.
   int         m_div, m_cnt, m_rep;
   logic [1:0] m_prev;
   logic [9:0] m_led;

   light_sequencer #(
      .DIV_D2(D2), .DIV_DP1(DP1), .DIV_D1(D1), .STEPS(STEPS), .REPS(REPS)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .state      (state),
      .enable     (enable),
      .count      (count),
      .repCount   (repCount),
      .ledPattern (ledPattern),
      .tick       (tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int per_of(input logic [1:0] s);
      return (s == 2'b00) ? D2 : (s == 2'b01) ? DP1 : D1;
   endfunction

   function automatic logic [9:0] pat(input int c, input logic [1:0] s);
      int v;
      if (s == 2'b00)      v = (c < 10) ? (1 << c) : 0;
      else if (s == 2'b01) v = (c >= 9) ? 32'h3FF : ((1 << (c + 1)) - 1);
      else                 v = (c % 2 == 0) ? 32'h3FF : 0;
      return v[9:0];
   endfunction

   function automatic logic exp_tick();
      return enable && (state == m_prev) && (m_div == per_of(state) - 1);
   endfunction

   task automatic model_reset();
      m_div = 0; m_cnt = 0; m_rep = REPS; m_prev = 2'b00; m_led = '0;
   endtask

   task automatic model_advance();
      logic t;
      t = exp_tick();
      m_led = enable ? pat(m_cnt, state) : 10'd0;
      if (state != m_prev) begin
         m_div = 0; m_cnt = 0; m_rep = REPS;
      end else if (enable) begin
         if (t) begin
            m_div = 0;
            if (state == 2'b01 && m_cnt == STEPS - 1 && m_rep > 0) m_rep--;
            m_cnt = (m_cnt + 1) % STEPS;
         end else begin
            m_div++;
         end
      end
      m_prev = state;
   endtask

   // Check all outputs mid-cycle, then advance one clock edge.
   task automatic step();
      @(negedge clk);
      chk("count", 32'(count), 32'(m_cnt));
      chk("repCount", 32'(repCount), 32'(m_rep));
      chk("ledPattern", 32'(ledPattern), 32'(m_led));
      chk("tick", 32'(tick), 32'(exp_tick()));
      @(posedge clk);
      model_advance();
      #1;
   endtask

   task automatic apply_reset();
      #2 reset = 1'b0;
      #1;
      chk("rst_count", 32'(count), 0);
      chk("rst_repCount", 32'(repCount), REPS);
      chk("rst_led", 32'(ledPattern), 0);
      chk("rst_tick", 32'(tick), 0);
      model_reset();
      @(posedge clk);
      #1 reset = 1'b1;
   endtask

   initial begin
      int n, wraps, prev_c, cnt0;
      model_reset();

      // Reset held, release, first tick in delay2.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_hold_count", 32'(count), 0);
      chk("rst_hold_rep", 32'(repCount), REPS);
      chk("rst_hold_led", 32'(ledPattern), 0);
      reset = 1'b1; enable = 1'b1; state = 2'b00;
      n = 0;
      while (count !== 6'd1 && n < 40) begin step(); n++; end
      chk("first_tick_latency", 32'(n), 8);
      step();
      chk("led_onehot_1", 32'(ledPattern), 32'h002);
      $display("txn reset/first tick: cycles=%0d led=%b", n, ledPattern);

      // delayPoint1 repetitions.
      state = 2'b01;
      n = 0;
      while (count !== 6'd2 && n < 40) begin step(); n++; end
      step();
      chk("led_bar_2", 32'(ledPattern), 32'h007);
      wraps = 0; n = 0;
      while (wraps < 4 && n < 120) begin
         prev_c = 32'(count);
         step(); n++;
         if (prev_c == 9 && count == 6'd0) begin
            wraps++;
            chk("rep_after_wrap", 32'(repCount), (wraps >= 3) ? 0 : REPS - wraps);
            $display("txn wrap %0d: repCount=%0d", wraps, repCount);
         end
      end
      chk("wrap_seen", 32'(wraps), 4);

      // State change coinciding with a tick.
      n = 0;
      while (tick !== 1'b1 && n < 20) begin step(); n++; end
      chk("tick_found", 32'(tick), 1);
      state = 2'b10;
      step();
      chk("chg_count", 32'(count), 0);
      chk("chg_rep", 32'(repCount), REPS);
      n = 0;
      while (count !== 6'd1 && n < 40) begin step(); n++; end
      chk("delay1_latency", 32'(n), 4);
      step();
      chk("led_flash_odd", 32'(ledPattern), 0);
      n = 0;
      while (count !== 6'd2 && n < 40) begin step(); n++; end
      step();
      chk("led_flash_even", 32'(ledPattern), 32'h3FF);
      $display("txn change-on-tick: count=%0d led=%h", count, ledPattern);

      // Enable dropped mid-period at divider 5.
      state = 2'b00;
      step();
      repeat (5) step();
      enable = 1'b0;
      cnt0 = 32'(count);
      repeat (20) begin
         step();
         chk("frozen_led", 32'(ledPattern), 0);
      end
      chk("frozen_count", 32'(count), 32'(cnt0));
      enable = 1'b1;
      n = 0;
      while (32'(count) == cnt0 && n < 40) begin step(); n++; end
      chk("resume_latency", 32'(n), 3);
      $display("txn enable pause: resume cycles=%0d count=%0d", n, count);

      // Reset in the middle of a delay1 period.
      state = 2'b10;
      repeat (3) step();
      apply_reset();
      $display("txn mid reset: count=%0d repCount=%0d", count, repCount);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         enable = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 23) == 0) state = 2'($urandom_range(0, 3));
         if (i == 300) apply_reset();
         step();
      end
      $display("txn random: count=%0d repCount=%0d led=%h", count, repCount, ledPattern);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/light_sequencer.md
LIGHT_SEQUENCER -- requirements
Module: light_sequencer

Interface
REQ-001 SHALL have parameter DIV_D2, default 100_000_000, meaning clocks per tick in delay2 (2 s at 50 MHz).
REQ-002 SHALL have parameter DIV_DP1, default 5_000_000, meaning clocks per tick in delayPoint1 (0.1 s).
REQ-003 SHALL have parameter DIV_D1, default 50_000_000, meaning clocks per tick in delay1 (1 s).
REQ-004 SHALL have parameter STEPS, default 10, meaning pattern steps per repetition (2..63).
REQ-005 SHALL have parameter REPS, default 3, meaning delayPoint1 repetitions loaded into repCount (1..15).
REQ-006 SHALL have port clk  input  1  single system clock; all logic on posedge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port state  input  2  delay-state code from the light-show state machine.
REQ-009 SHALL have port enable  input  1  run permission; high = sequence advances.
REQ-010 SHALL have port count  output  6  current step index within a repetition.
REQ-011 SHALL have port repCount  output  4  remaining delayPoint1 repetitions.
REQ-012 SHALL have port ledPattern  output  10  LED drive, bit 0 = rightmost LED.
REQ-013 SHALL have port tick  output  1  one-cycle pulse on each step advance.

Function
REQ-014 SHALL select tick period: state 00 -> DIV_D2, 01 -> DIV_DP1, 10 -> DIV_D1, 11 -> DIV_D1.
REQ-015 SHALL run a 27-bit divider counting 0..DIV-1 while enable=1; tick=1 in the cycle the divider equals DIV-1, divider returns to 0 next cycle.
REQ-016 SHALL hold divider, count, repCount and suppress tick while enable=0.
REQ-017 SHALL on each tick increment count, wrapping STEPS-1 -> 0.
REQ-018 SHALL in state 01, on a tick that wraps count, decrement repCount if nonzero; repCount saturates at 0.
REQ-019 SHALL register the previous state; on a cycle where state differs from it, clear divider and count to 0, reload repCount=REPS, and suppress tick that cycle.
REQ-020 SHALL give state change priority over a coincident tick: no count increment, no repCount decrement.
REQ-021 SHALL drive ledPattern registered from count and state: 00 -> one-hot (1 << count); 01 -> bar, lowest count+1 bits set; 10/11 -> all ten bits 1 when count even, 0 when odd.
REQ-022 SHALL force ledPattern to 0 while enable=0, updating one cycle after enable changes.
REQ-023 SHALL mask pattern bits >= 10 when count exceeds 9 (STEPS>10).
REQ-024 SHALL update ledPattern one clock after count changes (one-cycle latency).

Reset
REQ-025 SHALL on reset=0 asynchronously set divider=0, count=0, repCount=REPS, ledPattern=0, tick=0, previous state=00.
REQ-026 SHALL after reset release resume at divider 0, with first tick DIV cycles after the first enabled edge.
REQ-027 SHALL abandon any partial period on reset mid-operation; no tick is emitted from the aborted period.

Structure
REQ-028 SHALL take state codes (00 delay2, 01 delayPoint1, 10 delay1) from a shared package also used by the light-show state machine.
REQ-029 SHALL implement divider plus tick in one sub-module, tick_gen (inputs clk, reset, clear, run, period; output tick).
REQ-030 SHALL keep step/repetition counters and the pattern decoder in light_sequencer itself.

Verification (parameters DIV_D2=8, DIV_DP1=2, DIV_D1=4, STEPS=10, REPS=3)
REQ-031 SHALL test reset held low, release, enable=1, state=00 -> first tick 8 cycles later, count=1, ledPattern=10'b0000000010 one cycle after.
REQ-032 SHALL test state=01 for 3 full repetitions -> repCount 3->2->1->0 on each count 9->0 wrap, holds 0 afterward; ledPattern=10'b0000000111 at count=2.
REQ-033 SHALL test state 01->10 coincident with tick -> no increment, count=0, repCount=3, next tick 4 cycles later, ledPattern alternates 3FF/000.
REQ-034 SHALL test enable dropped mid-period at divider=5 for 20 cycles -> count frozen, no tick, ledPattern=0; on re-enable, tick after 3 more cycles.
REQ-035 SHALL test reset asserted mid-period in state 10 -> all outputs at reset values same cycle, repCount=3.
